// File: rtl/alu_seq.sv
// alu_seq: registered ALU with carry/zero flags, rotate-by-any-amount and an
// iterative shift-add multiplier producing a 2*WIDTH-bit product.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        operation request, accepted only while busy=0
//   op[3:0]      operation code
//   rs           destination for single-cycle ops (0: r_out, 1: s_out)
//   x, y         operands, sampled when start is accepted
//   r_out, s_out result registers (MUL: low half / high half)
//   carry, zero  status flags
//   busy         multiply in progress
//   done         one-cycle pulse after a result has been written
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             rs,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] s_out,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0]       OP_MUL   = 4'd11;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH:0]   W_VEC    = (WIDTH + 1)'(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     alu_res;

  // Single-cycle result: bit WIDTH is the carry, low bits are the result.
  function automatic logic [WIDTH:0] alu(input logic [3:0] code,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    logic [WIDTH:0]     r;
    logic [WIDTH:0]     amt;
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] rot;
    r   = '0;
    amt = {1'b0, b} % W_VEC;
    dbl = {a, a};
    rot = '0;
    case (code)
      4'd0:  r[WIDTH-1:0] = a & b;
      4'd1:  r[WIDTH-1:0] = a | b;
      4'd2:  r[WIDTH-1:0] = ~a;
      4'd3:  r[WIDTH-1:0] = a ^ b;
      4'd4:  r = {a[0], b[0], a[WIDTH-1:1]};
      4'd5:  r = {a[WIDTH-1], a[WIDTH-2:0], b[WIDTH-1]};
      4'd6: begin
        rot = dbl >> amt;
        r[WIDTH-1:0] = rot[WIDTH-1:0];
      end
      4'd7: begin
        rot = dbl << amt;
        r[WIDTH-1:0] = rot[2*WIDTH-1:WIDTH];
      end
      4'd8:  r = {1'b0, a} + {1'b0, b};
      // Carry out of x + ~y + 1 is the "no borrow" indication.
      4'd9:  r = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      4'd10: r[0] = (a == b);
      4'd12: begin
        for (int i = 0; i < WIDTH; i++) r[i] = a[WIDTH-1-i];
      end
      4'd13: r[0] = ^a;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_res = alu(op, x, y);

  // One shift-add step: conditional add into the upper half, with the add
  // carry kept in bit WIDTH so the following right shift brings it down.
  assign mul_sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
  assign prod    = {mul_sum, mplier[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && op == OP_MUL) state_next = MUL;
      MUL:  if (cnt == CNT_ONE)        state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MUL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out  <= '0;
      s_out  <= WIDTH'(1);
      carry  <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand  <= x;
              mplier <= y;
              acc    <= '0;
              cnt    <= CNT_INIT;
            end else begin
              if (rs) s_out <= alu_res[WIDTH-1:0];
              else    r_out <= alu_res[WIDTH-1:0];
              carry <= alu_res[WIDTH];
              zero  <= (alu_res[WIDTH-1:0] == '0);
              done  <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= mul_sum[WIDTH:1];
          mplier <= {mul_sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt - CNT_ONE;
          // Last iteration: the shifted value is the finished product.
          if (cnt == CNT_ONE) begin
            r_out <= prod[WIDTH-1:0];
            s_out <= prod[2*WIDTH-1:WIDTH];
            carry <= 1'b0;
            zero  <= (prod == '0);
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, rs8 = 1'b0;
  logic [3:0]  op8 = '0;
  logic [7:0]  x8 = '0, y8 = '0, r8, s8;
  logic        c8, z8, b8, d8;

  logic        start16 = 1'b0, rs16 = 1'b0;
  logic [3:0]  op16 = '0;
  logic [15:0] x16 = '0, y16 = '0, r16, s16;
  logic        c16, z16, b16, d16;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .rs(rs8),
    .x(x8), .y(y8), .r_out(r8), .s_out(s8), .carry(c8), .zero(z8),
    .busy(b8), .done(d8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .rs(rs16),
    .x(x16), .y(y16), .r_out(r16), .s_out(s16), .carry(c16), .zero(z16),
    .busy(b16), .done(d16)
  );

  int checks = 0;
  int errors = 0;

  // Expected architectural state, index 0 = WIDTH 8, index 1 = WIDTH 16.
  logic [63:0] exp_r [2];
  logic [63:0] exp_s [2];
  logic        exp_c [2];
  logic        exp_z [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Reference: each op written directly from its arithmetic definition.
  function automatic void model(input int w, input logic [3:0] opc,
                                input longint unsigned a, input longint unsigned b,
                                output longint unsigned res, output logic c);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned amt = b % longint'(w);
    res = 0;
    c = 1'b0;
    case (opc)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2:  res = ~a & mask;
      4'd3:  res = a ^ b;
      4'd4:  begin res = (a >> 1) | ((b & 1) << (w - 1)); c = a[0]; end
      4'd5:  begin res = ((a << 1) & mask) | ((b >> (w - 1)) & 1); c = a[w-1]; end
      4'd6:  res = ((a >> amt) | (a << (w - amt))) & mask;
      4'd7:  res = ((a << amt) | (a >> (w - amt))) & mask;
      4'd8:  begin res = (a + b) & mask; c = ((a + b) >> w) != 0; end
      4'd9:  begin res = (a - b) & mask; c = (a >= b); end
      4'd10: res = (a == b) ? 1 : 0;
      4'd11: res = a * b;
      4'd12: for (int i = 0; i < w; i++) if (a[i]) res = res | (64'd1 << (w - 1 - i));
      4'd13: res = $countones(a) % 2;
      default: res = 0;
    endcase
  endfunction

  task automatic drive(input int w, input logic st, input logic [3:0] opc,
                       input logic dst, input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      start8 = st; op8 = opc; rs8 = dst; x8 = a[7:0]; y8 = b[7:0];
    end else begin
      start16 = st; op16 = opc; rs16 = dst; x16 = a; y16 = b;
    end
  endtask

  task automatic check_state(input int w, input string tag, input logic want_done);
    int i = (w == 8) ? 0 : 1;
    logic [63:0] r, s;
    logic c, z, b, d;
    if (w == 8) begin
      r = {56'b0, r8}; s = {56'b0, s8}; c = c8; z = z8; b = b8; d = d8;
    end else begin
      r = {48'b0, r16}; s = {48'b0, s16}; c = c16; z = z16; b = b16; d = d16;
    end
    chk({tag, "_r_out"}, r, exp_r[i]);
    chk({tag, "_s_out"}, s, exp_s[i]);
    chk({tag, "_carry"}, {63'b0, c}, {63'b0, exp_c[i]});
    chk({tag, "_zero"},  {63'b0, z}, {63'b0, exp_z[i]});
    chk({tag, "_busy"},  {63'b0, b}, 64'd0);
    chk({tag, "_done"},  {63'b0, d}, {63'b0, want_done});
  endtask

  task automatic set_reset_model();
    for (int i = 0; i < 2; i++) begin
      exp_r[i] = 0; exp_s[i] = 1; exp_c[i] = 1'b0; exp_z[i] = 1'b0;
    end
  endtask

  task automatic single(input int w, input logic [3:0] opc, input logic dst,
                        input logic [15:0] a, input logic [15:0] b);
    int i = (w == 8) ? 0 : 1;
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned res;
    logic c;
    model(w, opc, a & mask, b & mask, res, c);
    @(negedge clk);
    drive(w, 1'b1, opc, dst, a, b);
    @(posedge clk);
    #1;
    drive(w, 1'b0, opc, dst, a, b);
    if (dst) exp_s[i] = res; else exp_r[i] = res;
    exp_c[i] = c;
    exp_z[i] = (res == 0);
    check_state(w, $sformatf("op%0d_w%0d", opc, w), 1'b1);
  endtask

  task automatic mul(input int w, input logic [15:0] a, input logic [15:0] b,
                     input logic collide);
    int i = (w == 8) ? 0 : 1;
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned p;
    logic c;
    int lat = 0;
    model(w, 4'd11, a & mask, b & mask, p, c);
    @(negedge clk);
    drive(w, 1'b1, 4'd11, 1'b0, a, b);
    @(posedge clk);
    #1;
    // Operands change right after acceptance; the latched copies must be used.
    drive(w, 1'b0, 4'd11, 1'b0, 16'($urandom), 16'($urandom));
    for (int k = 1; k <= w + 4; k++) begin
      chk("mul_busy_during", {63'b0, (w == 8) ? b8 : b16}, 64'd1);
      if (collide && k == 3) drive(w, 1'b1, 4'd8, 1'b0, 16'($urandom), 16'($urandom));
      @(posedge clk);
      #1;
      drive(w, 1'b0, 4'd8, 1'b0, 16'($urandom), 16'($urandom));
      if ((w == 8) ? d8 : d16) begin
        lat = k;
        break;
      end
    end
    chk("mul_latency", 64'(lat), 64'(w));
    exp_r[i] = p & mask;
    exp_s[i] = p >> w;
    exp_c[i] = 1'b0;
    exp_z[i] = (p == 0);
    check_state(w, "mul", 1'b1);
    @(posedge clk);
    #1;
    chk("mul_done_pulse", {63'b0, (w == 8) ? d8 : d16}, 64'd0);
  endtask

  initial begin
    set_reset_model();
    #12;
    check_state(8, "por", 1'b0);
    check_state(16, "por", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    single(8, 4'd8, 1'b0, 16'hF0, 16'h20);
    chk("add_const", {56'b0, r8}, 64'h10);
    chk("add_carry", {63'b0, c8}, 64'd1);
    single(8, 4'd9, 1'b1, 16'd5, 16'd7);
    chk("sub_const", {56'b0, s8}, 64'hFE);
    single(8, 4'd9, 1'b0, 16'd7, 16'd7);
    chk("sub_zero", {63'b0, z8}, 64'd1);
    single(8, 4'd6, 1'b0, 16'h81, 16'd9);
    chk("ror_const", {56'b0, r8}, 64'hC0);
    single(8, 4'd7, 1'b0, 16'h81, 16'd3);
    chk("rol_const", {56'b0, r8}, 64'h0C);
    single(8, 4'd5, 1'b0, 16'h80, 16'h80);
    chk("lsc_const", {56'b0, r8}, 64'h01);
    chk("lsc_carry", {63'b0, c8}, 64'd1);

    mul(8, 16'd13, 16'd11, 1'b0);
    chk("mul13_r", {56'b0, r8}, 64'h8F);
    chk("mul13_s", {56'b0, s8}, 64'h00);
    mul(8, 16'd200, 16'd200, 1'b0);
    chk("mul200_s", {56'b0, s8}, 64'h9C);
    chk("mul200_r", {56'b0, r8}, 64'h40);
    mul(8, 16'd0, 16'hFF, 1'b0);
    chk("mul0_zero", {63'b0, z8}, 64'd1);
    mul(8, 16'($urandom), 16'($urandom), 1'b1);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    set_reset_model();
    check_state(8, "async_rst", 1'b0);
    check_state(16, "async_rst", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Abort a multiply partway through.
    @(negedge clk);
    drive(8, 1'b1, 4'd11, 1'b0, 16'd13, 16'd11);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 4'd11, 1'b0, 16'd13, 16'd11);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    set_reset_model();
    check_state(8, "abort", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", {63'b0, d8}, 64'd0);
    end
    mul(8, 16'd13, 16'd11, 1'b0);

    mul(16, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("mul16_s", {48'b0, s16}, 64'hFFFE);
    chk("mul16_r", {48'b0, r16}, 64'h0001);
    single(16, 4'd6, 1'b0, 16'h0001, 16'd17);
    chk("ror16_const", {48'b0, r16}, 64'h8000);

    for (int n = 0; n < 80; n++) begin
      int w = $urandom_range(0, 1) ? 16 : 8;
      logic [3:0] opc = 4'($urandom_range(0, 15));
      if (opc == 4'd11) mul(w, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      else single(w, opc, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 9-bit CPU's combinational ALU. It accepts one operation per start pulse and writes the result into output registers r_out or s_out. It also maintains carry and zero flags. It adds an iterative shift-add multiplier that writes a double-width product, and rotates by any amount modulo WIDTH. It sits between the register file and the writeback mux; the control FSM waits on done for multi-cycle ops.

## Interface
Parameters:
- WIDTH, 8: operand/result width; must be ≥ 2.
- CNT_W, $clog2(WIDTH+1): multiply iteration counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; sampled on rising edge only when busy=0.
- op  in  4  operation code (see Operation).
- rs  in  1  destination for single-cycle ops: 0 → r_out, 1 → s_out.
- x, y  in  WIDTH  operands; sampled when start is accepted.
- r_out  out  WIDTH  result register R.
- s_out  out  WIDTH  result register S.
- carry  out  1  carry/shift-out flag.
- zero  out  1  set when the last written result is all zeros.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse when a result has been written.

## Operation
- Reset values: r_out=0, s_out=1, carry=0, zero=0, busy=0, done=0. The FSM resets to IDLE and the counter to 0.
- Op codes and results (res is WIDTH bits):
  - 0 AND: x&y.
  - 1 OR: x|y.
  - 2 NOT: ~x.
  - 3 XOR: x^y.
  - 4 RSC: {y[0], x[W-1:1]}; carry=x[0].
  - 5 LSC: {x[W-2:0], y[W-1]}; carry=x[W-1].
  - 6 ROR: x rotated right by y mod WIDTH.
  - 7 ROL: x rotated left by y mod WIDTH.
  - 8 ADD: x+y; carry=bit W of the W+1-bit sum.
  - 9 SUB: x+~y+1; carry=1 iff no borrow (x≥y unsigned).
  - 10 EQL: {0…, x==y}.
  - 11 MUL: unsigned x*y, 2·WIDTH-bit product.
  - 12 REV: bit-reverse of x.
  - 13 PAR: {0…, ^x}.
  - 14, 15 reserved: res=0; carry cleared.
- Carry is cleared by every op other than RSC, LSC, ADD, SUB and MUL. MUL clears carry.
- zero=(res==0) for single-cycle ops; for MUL, zero=(product==0).
- For single-cycle ops, rs selects which register is written; the other register holds its value. MUL ignores rs and writes both registers: low half → r_out, high half → s_out.
- FSM states:
  - IDLE: accepting start.
  - MUL: busy, iterating.
- Transitions:
  - IDLE → IDLE on start with a single-cycle op: result written at the same edge.
  - IDLE → MUL on start with op=11: latch x as the multiplicand and y as the multiplier; clear the accumulator; set counter=WIDTH.
  - MUL: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator's upper half. Then shift {carry, accumulator, multiplier} right by 1 and decrement the counter.
  - MUL → IDLE when the counter reaches 0: write r_out/s_out/zero/carry.
- Accumulator arithmetic is WIDTH+1 bits to hold the add carry; the product never overflows 2·WIDTH bits.
- start while busy=1 is ignored: no queueing and no effect on the operation in flight.
- start is not acted on in the MUL→IDLE transition cycle, because busy is still 1 at that edge.
- Reset asserted mid-MUL aborts the multiply. All outputs return to reset values and no done pulse is issued.

## Timing
- Single-cycle op accepted at edge E0: outputs and flags are valid after E0, done=1 for the one cycle following E0, and busy stays 0. A new start may be accepted at E0+1, giving a back-to-back throughput of 1 op/cycle.
- MUL accepted at E0:
  - busy=1 from after E0 through edge E0+WIDTH.
  - The result is written at E0+WIDTH, where busy falls and done=1 for the following cycle.
  - Latency is WIDTH cycles; the next start is accepted at E0+WIDTH+1 at the earliest.
- done never stays high two consecutive cycles unless two single-cycle ops are accepted on consecutive edges.
- x and y may change freely after acceptance; the multiply uses its latched copies.
- Outputs change only on a clk edge or on reset assertion.

## Test plan
- Reset then idle: assert reset asynchronously mid-cycle → r_out=0x00, s_out=0x01, carry=0, zero=0, busy=0, done=0 immediately.
- ADD/SUB flags (WIDTH=8):
  - ADD x=0xF0, y=0x20, rs=0 → r_out=0x10, carry=1, zero=0, done one cycle.
  - SUB x=5, y=7, rs=1 → s_out=0xFE, carry=0.
  - SUB x=7, y=7 → res=0x00, zero=1, carry=1.
- Rotate modulo: ROR x=0x81, y=9 → 0xC0. ROL x=0x81, y=3 → 0x0C. LSC x=0x80, y=0x80 → 0x01, carry=1.
- MUL:
  - x=13, y=11 → busy for 8 cycles, then r_out=0x8F, s_out=0x00, done pulse exactly 8 edges after acceptance.
  - x=200, y=200 → s_out=0x9C, r_out=0x40.
  - x=0, y=0xFF → zero=1.
- Busy collision and abort:
  - start ADD during MUL → ignored; MUL result is unchanged.
  - Assert reset at MUL cycle 4 → reset values, no done. A fresh MUL afterwards completes correctly.
- Parametrisation: repeat MUL and ROR with WIDTH=16 (0xFFFF*0xFFFF → s_out=0xFFFE, r_out=0x0001, latency 16; ROR 0x0001 by 17 → 0x8000).
